// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: instruction/operand input side, ALU operand output side and flush.
// master = upstream/downstream environment, slave = the issue stage itself.
interface alu_issue_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_data_1;
    logic [31:0] alu_data_2;
    logic [3:0]  alu_op;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic [2:0]  out_funct3;
    logic [31:0] out_pc;
    logic        out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, flush, out_ready,
        input  in_ready, out_valid, alu_data_1, alu_data_2, alu_op, out_rd,
               out_reg_write, out_mem_read, out_mem_write, out_funct3, out_pc, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, flush, out_ready,
        output in_ready, out_valid, alu_data_1, alu_data_2, alu_op, out_rd,
               out_reg_write, out_mem_read, out_mem_write, out_funct3, out_pc, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: decodes one instruction into ALU operands, op and sidebands,
// held in a single-entry output register with valid/ready handshake and flush.
module alu_issue_stage #(
    parameter bit ILLEGAL_PASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_stage_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3,
                           OP_SLTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                           OP_OR = 4'd8, OP_AND = 4'd9;

    localparam logic [6:0] OPC_OP = 7'b0110011, OPC_OPIMM = 7'b0010011, OPC_LUI = 7'b0110111,
                           OPC_AUIPC = 7'b0010111, OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011,
                           OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011;

    function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  f3_op = alt ? OP_SUB : OP_ADD;
            3'b001:  f3_op = OP_SLL;
            3'b010:  f3_op = OP_SLT;
            3'b011:  f3_op = OP_SLTU;
            3'b100:  f3_op = OP_XOR;
            3'b101:  f3_op = alt ? OP_SRA : OP_SRL;
            3'b110:  f3_op = OP_OR;
            default: f3_op = OP_AND;
        endcase
    endfunction

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] imm_i, imm_s, imm_u;

    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'b0};

    logic [31:0] dec_d1, dec_d2;
    logic [3:0]  dec_op;
    logic        dec_rw, dec_mr, dec_mw, dec_ill;

    always_comb begin
        dec_d1  = bus.in_rs1_data;
        dec_d2  = bus.in_rs2_data;
        dec_op  = OP_ADD;
        dec_rw  = 1'b0;
        dec_mr  = 1'b0;
        dec_mw  = 1'b0;
        dec_ill = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_rw = 1'b1;
                if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))
                    dec_op = f3_op(f3, f7[5]);
                else
                    dec_ill = 1'b1;
            end
            OPC_OPIMM: begin
                dec_rw = 1'b1;
                dec_d2 = imm_i;
                if (f3 == 3'b001) begin
                    dec_d2  = {27'b0, instr[24:20]};
                    dec_op  = OP_SLL;
                    dec_ill = (f7 != 7'b0000000);
                end else if (f3 == 3'b101) begin
                    dec_d2  = {27'b0, instr[24:20]};
                    dec_op  = f7[5] ? OP_SRA : OP_SRL;
                    dec_ill = !(f7 == 7'b0000000 || f7 == 7'b0100000);
                end else begin
                    dec_op = f3_op(f3, 1'b0);
                end
            end
            OPC_LUI: begin
                dec_d1 = 32'd0;
                dec_d2 = imm_u;
                dec_rw = 1'b1;
            end
            OPC_AUIPC: begin
                dec_d1 = bus.in_pc;
                dec_d2 = imm_u;
                dec_rw = 1'b1;
            end
            OPC_LOAD: begin
                dec_d2 = imm_i;
                dec_mr = 1'b1;
                dec_rw = 1'b1;
            end
            OPC_STORE: begin
                dec_d2 = imm_s;
                dec_mw = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                dec_d1 = bus.in_pc;
                dec_d2 = 32'd4;
                dec_rw = 1'b1;
            end
            OPC_BRANCH: begin
                case (f3[2:1])
                    2'b00:   dec_op = OP_SUB;
                    2'b10:   dec_op = OP_SLT;
                    2'b11:   dec_op = OP_SLTU;
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
        // An illegal entry carries a neutral ADD 0+0 with every side effect disabled.
        if (dec_ill) begin
            dec_op = OP_ADD;
            dec_d1 = 32'd0;
            dec_d2 = 32'd0;
            dec_rw = 1'b0;
            dec_mr = 1'b0;
            dec_mw = 1'b0;
        end
        if (rd == 5'd0)
            dec_rw = 1'b0;
    end

    // Handshake: a beat moves on a side when valid && ready are both high at the rising
    // edge; in_ready = !out_valid || out_ready; flush kills the held entry and same-cycle input.
    logic        valid_q;
    logic        ready;
    logic        keep;

    assign ready = !valid_q || bus.out_ready;
    assign keep  = bus.in_valid && (ILLEGAL_PASS || !dec_ill);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q           <= 1'b0;
            bus.alu_data_1    <= 32'd0;
            bus.alu_data_2    <= 32'd0;
            bus.alu_op        <= OP_ADD;
            bus.out_rd        <= 5'd0;
            bus.out_reg_write <= 1'b0;
            bus.out_mem_read  <= 1'b0;
            bus.out_mem_write <= 1'b0;
            bus.out_funct3    <= 3'd0;
            bus.out_pc        <= 32'd0;
            bus.out_illegal   <= 1'b0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (ready) begin
            valid_q <= keep;
            if (keep) begin
                bus.alu_data_1    <= dec_d1;
                bus.alu_data_2    <= dec_d2;
                bus.alu_op        <= dec_op;
                bus.out_rd        <= rd;
                bus.out_reg_write <= dec_rw;
                bus.out_mem_read  <= dec_mr;
                bus.out_mem_write <= dec_mw;
                bus.out_funct3    <= f3;
                bus.out_pc        <= bus.in_pc;
                bus.out_illegal   <= dec_ill;
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.in_ready  = ready;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, backpressure ordering, flush and reset.
module tb_alu_issue_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    localparam logic [3:0] E_ADD = 4'd0, E_SUB = 4'd1, E_SLTU = 4'd4, E_SRA = 4'd7, E_OR = 4'd8;

    alu_issue_stage_if bus ();

    alu_issue_stage #(.ILLEGAL_PASS(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        bus.in_valid    = v;
        bus.in_instr    = instr;
        bus.in_pc       = pc;
        bus.in_rs1_data = rs1;
        bus.in_rs2_data = rs2;
    endtask

    // Offer one instruction with out_ready=1 and check the entry issued after the next edge.
    task automatic run_vec(input string name, input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] e_d1, input logic [31:0] e_d2, input logic [3:0] e_op,
                           input logic [4:0] e_rd, input logic e_rw, input logic e_mr,
                           input logic e_mw, input logic e_ill, input logic [2:0] e_f3);
        drive(1'b1, instr, pc, rs1, rs2);
        bus.out_ready = 1'b1;
        tick();
        check({name, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({name, ".d1"}, bus.alu_data_1, e_d1);
        check({name, ".d2"}, bus.alu_data_2, e_d2);
        check({name, ".op"}, {28'd0, bus.alu_op}, {28'd0, e_op});
        check({name, ".rd"}, {27'd0, bus.out_rd}, {27'd0, e_rd});
        check({name, ".rw"}, {31'd0, bus.out_reg_write}, {31'd0, e_rw});
        check({name, ".mr"}, {31'd0, bus.out_mem_read}, {31'd0, e_mr});
        check({name, ".mw"}, {31'd0, bus.out_mem_write}, {31'd0, e_mw});
        check({name, ".ill"}, {31'd0, bus.out_illegal}, {31'd0, e_ill});
        check({name, ".f3"}, {29'd0, bus.out_funct3}, {29'd0, e_f3});
        check({name, ".pc"}, bus.out_pc, pc);
    endtask

    // Scoreboard for the backpressure phase: each consumed beat must match the queue head.
    logic [31:0] exp_q[$];
    logic        mon_en = 1'b0;
    int          beats = 0;

    always @(negedge clk) begin
        if (mon_en && bus.out_valid && bus.out_ready) begin
            beats++;
            if (exp_q.size() == 0)
                check("bp.extra_beat", bus.alu_data_1, 32'hxxxx_xxxx);
            else
                check("bp.order", bus.alu_data_1, exp_q.pop_front());
        end
    end

    task automatic check_reset_state(input string name);
        check({name, ".valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({name, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        check({name, ".d1"}, bus.alu_data_1, 32'd0);
        check({name, ".d2"}, bus.alu_data_2, 32'd0);
        check({name, ".op"}, {28'd0, bus.alu_op}, {28'd0, E_ADD});
        check({name, ".pc"}, bus.out_pc, 32'd0);
        check({name, ".rw"}, {31'd0, bus.out_reg_write}, 32'd0);
        check({name, ".ill"}, {31'd0, bus.out_illegal}, 32'd0);
    endtask

    initial begin
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        check_reset_state("reset");
        rst = 1'b0;

        // Decode vectors back to back, one beat per cycle.
        run_vec("add",   32'h002081B3, 32'h0,    32'd5,        32'd7,  32'd5,        32'd7,        E_ADD,  5'd3,  1, 0, 0, 0, 3'd0);
        run_vec("sub",   32'h402081B3, 32'h4,    32'd5,        32'd7,  32'd5,        32'd7,        E_SUB,  5'd3,  1, 0, 0, 0, 3'd0);
        run_vec("sra",   32'h4020D1B3, 32'h8,    32'd5,        32'd7,  32'd5,        32'd7,        E_SRA,  5'd3,  1, 0, 0, 0, 3'd5);
        run_vec("srai",  32'h4040D093, 32'hC,    32'h80000000, 32'd9,  32'h80000000, 32'd4,        E_SRA,  5'd1,  1, 0, 0, 0, 3'd5);
        run_vec("ori",   32'hFFF0E193, 32'h10,   32'h0000000F, 32'd9,  32'h0000000F, 32'hFFFFFFFF, E_OR,   5'd3,  1, 0, 0, 0, 3'd6);
        run_vec("lui",   32'h123452B7, 32'h14,   32'h0000DEAD, 32'd1,  32'd0,        32'h12345000, E_ADD,  5'd5,  1, 0, 0, 0, 3'd5);
        run_vec("auipc", 32'h00001117, 32'h1000, 32'd3,        32'd4,  32'h1000,     32'h1000,     E_ADD,  5'd2,  1, 0, 0, 0, 3'd1);
        run_vec("sw",    32'hFE20AE23, 32'h18,   32'h100,      32'h77, 32'h100,      32'hFFFFFFFC, E_ADD,  5'd28, 0, 0, 1, 0, 3'd2);
        run_vec("lw",    32'hFFC0A183, 32'h1C,   32'h200,      32'h77, 32'h200,      32'hFFFFFFFC, E_ADD,  5'd3,  1, 1, 0, 0, 3'd2);
        run_vec("jal",   32'h008000EF, 32'h200,  32'd11,       32'd12, 32'h200,      32'd4,        E_ADD,  5'd1,  1, 0, 0, 0, 3'd0);
        run_vec("bltu",  32'h0020E063, 32'h24,   32'd3,        32'd9,  32'd3,        32'd9,        E_SLTU, 5'd0,  0, 0, 0, 0, 3'd6);
        run_vec("ill",   32'hFFFFFFFF, 32'h28,   32'd3,        32'd9,  32'd0,        32'd0,        E_ADD,  5'd31, 0, 0, 0, 1, 3'd7);
        run_vec("br010", 32'h0020A063, 32'h2C,   32'd3,        32'd9,  32'd0,        32'd0,        E_ADD,  5'd0,  0, 0, 0, 1, 3'd2);
        run_vec("slli7", 32'h40109093, 32'h30,   32'd3,        32'd9,  32'd0,        32'd0,        E_ADD,  5'd1,  0, 0, 0, 1, 3'd1);
        run_vec("addx0", 32'h00208033, 32'h34,   32'd5,        32'd7,  32'd5,        32'd7,        E_ADD,  5'd0,  0, 0, 0, 0, 3'd0);

        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        check("drain.valid", {31'd0, bus.out_valid}, 32'd0);

        // Backpressure: three ADDs tagged by rs1 value, output held for three cycles.
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'h40, 32'd10, 32'd1);
        tick();
        exp_q.push_back(32'd10);
        drive(1'b1, 32'h002081B3, 32'h44, 32'd20, 32'd2);
        for (int i = 0; i < 3; i++) begin
            check("bp.hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp.hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("bp.hold_d1", bus.alu_data_1, 32'd10);
            check("bp.hold_pc", bus.out_pc, 32'h40);
            tick();
        end
        exp_q.push_back(32'd20);
        exp_q.push_back(32'd30);
        mon_en = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        drive(1'b1, 32'h002081B3, 32'h48, 32'd30, 32'd3);
        tick();
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        mon_en = 1'b0;
        check("bp.beats", beats, 32'd3);
        check("bp.queue_left", exp_q.size(), 32'd0);
        check("bp.empty_after", {31'd0, bus.out_valid}, 32'd0);

        // Flush with an entry held and a new instruction offered.
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'h50, 32'h55, 32'd1);
        tick();
        check("fl.loaded", {31'd0, bus.out_valid}, 32'd1);
        bus.flush = 1'b1;
        drive(1'b1, 32'h002081B3, 32'h54, 32'h66, 32'd1);
        tick();
        bus.flush = 1'b0;
        check("fl.killed", {31'd0, bus.out_valid}, 32'd0);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        check("fl.not_issued", {31'd0, bus.out_valid}, 32'd0);

        // Flush on an empty stage while input is offered and in_ready is high.
        bus.out_ready = 1'b1;
        bus.flush = 1'b1;
        drive(1'b1, 32'h002081B3, 32'h58, 32'h77, 32'd1);
        tick();
        bus.flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        check("fl.empty", {31'd0, bus.out_valid}, 32'd0);
        tick();
        check("fl.empty2", {31'd0, bus.out_valid}, 32'd0);

        // Reset mid-stream while an entry is stalled.
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hFFF0E193, 32'h60, 32'h0F, 32'd1);
        tick();
        check("rs.loaded", {31'd0, bus.out_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        check_reset_state("midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Registered decode/issue stage that produces the ALU's operand and operation inputs. It turns a fetched RV32I instruction, its PC and the register-file read data into `alu_data_1`, `alu_data_2` and `alu_op`, plus writeback and memory-control sidebands. It sits between fetch/register-read and the execute stage. It has a single-entry pipeline register with valid/ready handshake and flush.

## Interface

- `ILLEGAL_PASS`, default 1: if 1, illegal instructions issue with `out_illegal`=1. If 0, they are accepted and dropped, producing no output beat.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: an instruction is offered.
- `in_ready` out 1: the stage accepts this cycle.
- `in_instr` in 32: instruction word.
- `in_pc` in 32: instruction address.
- `in_rs1_data` in 32: register-file value of rs1.
- `in_rs2_data` in 32: register-file value of rs2.
- `flush` in 1: kill the held entry and any same-cycle input.
- `out_valid` out 1: the issued entry is valid.
- `out_ready` in 1: execute consumes this cycle.
- `alu_data_1` out 32: ALU operand 1.
- `alu_data_2` out 32: ALU operand 2.
- `alu_op` out 4: operation, encoded per ALU_OP_ENUM.
- `out_rd` out 5: destination register.
- `out_reg_write` out 1: writeback enable.
- `out_mem_read` out 1: load.
- `out_mem_write` out 1: store.
- `out_funct3` out 3: funct3 passthrough, for memory size and branch condition.
- `out_pc` out 32: PC passthrough.
- `out_illegal` out 1: undecodable instruction.

## Operation

- `in_ready = !out_valid || out_ready`, combinational. A transfer occurs when `in_valid && in_ready && !flush`.
- **OP (0110011):** d1=rs1, d2=rs2.
  - funct3 selects the operation: 000 ADD, or SUB when funct7=0100000; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when funct7=0100000; 110 OR; 111 AND.
  - funct7 must be 0000000, or 0100000 only with funct3 000/101; anything else is illegal.
- **OP-IMM (0010011):** d1=rs1, d2=sign-extended I-imm.
  - funct3 mapping is as for OP, with no SUB.
  - Shifts (001/101): d2={27'b0, instr[24:20]}.
  - Shift funct7 must be 0000000; 0100000 is allowed only with 101, which selects SRA. Anything else is illegal.
- **LUI (0110111):** d1=0, d2={instr[31:12],12'b0}, op ADD.
- **AUIPC (0010111):** d1=pc, d2=U-imm, op ADD.
- **LOAD (0000011):** rs1 + I-imm, op ADD, mem_read=1, reg_write=1.
- **STORE (0100011):** rs1 + S-imm, op ADD, mem_write=1, reg_write=0.
- **JAL (1101111) / JALR (1100111):** d1=pc, d2=4, op ADD (link value), reg_write=1.
- **BRANCH (1100011):** d1=rs1, d2=rs2, reg_write=0.
  - 000/001 → SUB; 100/101 → SLT; 110/111 → SLTU.
  - 010/011 are illegal.
- **Any other opcode:** illegal.
- **Illegal entry:** alu_op=ADD, d1=d2=0, reg_write=mem_read=mem_write=0, out_illegal=1.
- `out_rd`=instr[11:7]. `out_reg_write` is forced to 0 when rd=0.
- Immediates are always sign-extended from instr[31]. All arithmetic is 32-bit, with no overflow flags.

## Timing

- Reset: `out_valid`=0; all data outputs 0; `alu_op`=ADD encoding; `out_illegal`=0. `in_ready`=1 after reset.
- Latency is 1 cycle: an instruction accepted at edge N appears on outputs after edge N with `out_valid`=1.
- Hold: while `out_valid && !out_ready`, all outputs stay stable and `in_ready`=0.
- Simultaneous consume and accept: the output register is reloaded with the new entry; there is no bubble, giving full throughput of 1/cycle.
- Consume with no new input: `out_valid` drops to 0 on the next edge.
- Flush has priority: on the next edge `out_valid`=0, and any same-cycle input is discarded even if `in_ready`=1. Data registers may keep stale values.
- `rst` mid-stream has priority over flush and transfer.
- `ILLEGAL_PASS`=0: an accepted illegal instruction leaves `out_valid`=0, or drops it if the held entry is consumed.

## Test plan

- **OP ADD/SUB:** rs1=5, rs2=7.
  - 0x002081B3 → d1=5, d2=7, ADD, rd=3, reg_write=1.
  - 0x402081B3 → SUB, same operands.
- **Immediates:**
  - SRAI 0x4040D093 → d2=4, SRA, rd=1.
  - LUI 0x123452B7 → d1=0, d2=0x12345000, ADD, rd=5.
  - SW 0xFE20AE23 with rs1=0x100 → d1=0x100, d2=0xFFFFFFFC, mem_write=1, reg_write=0, funct3=010.
- **Backpressure:** issue 3 back-to-back ADDs and hold `out_ready`=0 for 3 cycles → outputs unchanged, `in_ready`=0. Releasing `out_ready` gives one beat per cycle in order, none lost or duplicated.
- **Flush:**
  - Flush with an entry held and `in_valid`=1 → next cycle `out_valid`=0, and the input is never issued.
  - Flush on an empty stage → stays empty.
- **Illegal and edge cases:**
  - `ILLEGAL_PASS`=1: 0xFFFFFFFF → `out_illegal`=1, all enables 0.
  - Branch funct3=010 is illegal.
  - `add x0,x1,x2` (0x00208033) → reg_write=0.
- **Reset mid-stream:** assert `rst` while `out_valid`=1 and `out_ready`=0 → next cycle `out_valid`=0, outputs 0, `in_ready`=1.
